// File: rtl/delay_init_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delay_init_counter_pkg
// Description : Shared direction/mode encodings and a clog2 helper for the
//               delay_init_counter family.
// Revision    : 1.0 - initial release
// ============================================================================
package delay_init_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold values 0..value-1; parents use it to size WIDTH from MODULUS.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage : delay_init_counter_pkg
`default_nettype wire

// File: rtl/delay_init_counter_step.sv
`default_nettype none
// ============================================================================
// Module      : delay_init_counter_step
// Description : Combinational next-count calculation for one enabled step,
//               with wrap or saturate handling at the range limits.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_init_counter_step
    import delay_init_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] i_cnt,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_next,
    output logic             o_limit_hit
);

    // One extra bit so cnt + STEP and cnt + MODULUS can never overflow.
    localparam logic [WIDTH:0]   C_MOD   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   C_MAX   = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0]   C_STEP  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] C_MAX_N = WIDTH'(MODULUS - 1);

    logic [WIDTH:0] w_cnt_ext;
    logic [WIDTH:0] w_sum;

    always_comb begin
        w_cnt_ext   = {1'b0, i_cnt};
        w_sum       = w_cnt_ext + C_STEP;
        o_next      = i_cnt;
        o_limit_hit = 1'b0;

        if (i_dir == DIR_UP) begin
            if (w_sum <= C_MAX) begin
                o_next = WIDTH'(w_sum);
            end else begin
                o_limit_hit = 1'b1;
                o_next      = (SATURATE == MODE_SAT) ? C_MAX_N : WIDTH'(w_sum - C_MOD);
            end
        end else begin
            if (w_cnt_ext >= C_STEP) begin
                o_next = WIDTH'(w_cnt_ext - C_STEP);
            end else begin
                o_limit_hit = 1'b1;
                o_next      = (SATURATE == MODE_SAT) ? '0 : WIDTH'(w_cnt_ext + C_MOD - C_STEP);
            end
        end
    end

endmodule : delay_init_counter_step
`default_nettype wire

// File: rtl/delay_init_counter.sv
`default_nettype none
// ============================================================================
// Module      : delay_init_counter
// Description : Parametrised up/down counter with init value, step, modulus,
//               wrap/saturate mode and a registered wrap/limit event flag.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_init_counter
    import delay_init_counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int INIT      = 0,
    parameter int MODULUS   = 256,
    parameter int STEP      = 1,
    parameter int SATURATE  = 0,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_en,
    input  logic                 io_dir,
    input  logic                 io_load,
    input  logic [WIDTH-1:0]     io_load_val,
    input  logic                 io_clear,
    output logic [OUT_WIDTH-1:0] io_out,
    output logic                 io_wrap
);

    generate
        if (WIDTH < 1 || WIDTH > 31) begin : g_check_width
            $error("delay_init_counter: WIDTH must be in 1..31");
        end
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_check_modulus
            $error("delay_init_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
        if (INIT < 0 || INIT >= MODULUS) begin : g_check_init
            $error("delay_init_counter: INIT must satisfy 0 <= INIT < MODULUS");
        end
        if (STEP < 1 || STEP >= MODULUS) begin : g_check_step
            $error("delay_init_counter: STEP must satisfy 1 <= STEP < MODULUS");
        end
        if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_check_mode
            $error("delay_init_counter: SATURATE must be 0 or 1");
        end
        if (OUT_WIDTH < WIDTH) begin : g_check_out_width
            $error("delay_init_counter: OUT_WIDTH must be >= WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] C_INIT  = WIDTH'(INIT);
    localparam logic [WIDTH:0]   C_MAX   = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] C_MAX_N = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] step_next;
    logic             step_limit_hit;

    delay_init_counter_step #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .STEP     (STEP),
        .SATURATE (SATURATE)
    ) u_step (
        .i_cnt       (cnt_q),
        .i_dir       (io_dir),
        .o_next      (step_next),
        .o_limit_hit (step_limit_hit)
    );

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (io_clear) begin
            cnt_d = C_INIT;
        end else if (io_load) begin
            // Out-of-range loads clamp to the top of the range rather than truncating.
            cnt_d = ({1'b0, io_load_val} > C_MAX) ? C_MAX_N : io_load_val;
        end else if (io_en) begin
            cnt_d  = step_next;
            wrap_d = step_limit_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= C_INIT;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign io_out  = OUT_WIDTH'(cnt_q);
    assign io_wrap = wrap_q;

endmodule : delay_init_counter
`default_nettype wire

// File: tb/tb_delay_init_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_init_counter
// Description : Directed self-checking bench for delay_init_counter; wrap,
//               saturate and 1-bit instances share one stimulus bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_init_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic       clear;

    logic [31:0] a_out;
    logic        a_wrap;
    logic [31:0] b_out;
    logic        b_wrap;
    logic [31:0] c_out;
    logic        c_wrap;

    int err_cnt;
    int chk_cnt;

    delay_init_counter #(
        .WIDTH(4), .INIT(2), .MODULUS(10), .STEP(3), .SATURATE(0), .OUT_WIDTH(32)
    ) u_dut_wrap (
        .clk(clk), .reset(reset), .io_en(en), .io_dir(dir), .io_load(load),
        .io_load_val(load_val), .io_clear(clear), .io_out(a_out), .io_wrap(a_wrap)
    );

    delay_init_counter #(
        .WIDTH(4), .INIT(2), .MODULUS(10), .STEP(3), .SATURATE(1), .OUT_WIDTH(32)
    ) u_dut_sat (
        .clk(clk), .reset(reset), .io_en(en), .io_dir(dir), .io_load(load),
        .io_load_val(load_val), .io_clear(clear), .io_out(b_out), .io_wrap(b_wrap)
    );

    delay_init_counter #(
        .WIDTH(1), .INIT(0), .MODULUS(2), .STEP(1), .SATURATE(0), .OUT_WIDTH(32)
    ) u_dut_bit (
        .clk(clk), .reset(reset), .io_en(en), .io_dir(dir), .io_load(load),
        .io_load_val(load_val[0]), .io_clear(clear), .io_out(c_out), .io_wrap(c_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        err_cnt  = 0;
        chk_cnt  = 0;
        reset    = 1'b1;
        en       = 1'b0;
        dir      = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        clear    = 1'b0;

        tick();
        check_val("rst_a_out",  a_out, 32'd2);
        check_val("rst_a_wrap", {31'd0, a_wrap}, 32'd0);
        check_val("rst_b_out",  b_out, 32'd2);
        check_val("rst_c_out",  c_out, 32'd0);
        check_val("rst_c_wrap", {31'd0, c_wrap}, 32'd0);

        // Count up from INIT: 5, 8, 1 (wrap), 4; the 1-bit counter toggles.
        reset = 1'b0; en = 1'b1; dir = 1'b1;
        tick();
        check_val("up1_a_out",  a_out, 32'd5);
        check_val("up1_a_wrap", {31'd0, a_wrap}, 32'd0);
        check_val("up1_c_out",  c_out, 32'h1);
        check_val("up1_c_wrap", {31'd0, c_wrap}, 32'd0);
        tick();
        check_val("up2_a_out",  a_out, 32'd8);
        check_val("up2_a_wrap", {31'd0, a_wrap}, 32'd0);
        check_val("up2_c_out",  c_out, 32'h0);
        check_val("up2_c_wrap", {31'd0, c_wrap}, 32'd1);
        tick();
        check_val("up3_a_out",  a_out, 32'd1);
        check_val("up3_a_wrap", {31'd0, a_wrap}, 32'd1);
        check_val("up3_b_out",  b_out, 32'd9);
        check_val("up3_b_wrap", {31'd0, b_wrap}, 32'd1);
        check_val("up3_c_out",  c_out, 32'h1);
        check_val("up3_c_wrap", {31'd0, c_wrap}, 32'd0);
        tick();
        check_val("up4_a_out",  a_out, 32'd4);
        check_val("up4_a_wrap", {31'd0, a_wrap}, 32'd0);
        check_val("up4_c_out",  c_out, 32'h0);
        check_val("up4_c_wrap", {31'd0, c_wrap}, 32'd1);

        // Down wrap: 1 - 3 wraps to 8, then 5.
        en = 1'b0; load = 1'b1; load_val = 4'd1;
        tick();
        check_val("ld1_a_out",  a_out, 32'd1);
        check_val("ld1_a_wrap", {31'd0, a_wrap}, 32'd0);
        load = 1'b0; en = 1'b1; dir = 1'b0;
        tick();
        check_val("dn1_a_out",  a_out, 32'd8);
        check_val("dn1_a_wrap", {31'd0, a_wrap}, 32'd1);
        check_val("dn1_b_out",  b_out, 32'd0);
        check_val("dn1_b_wrap", {31'd0, b_wrap}, 32'd1);
        tick();
        check_val("dn2_a_out",  a_out, 32'd5);
        check_val("dn2_a_wrap", {31'd0, a_wrap}, 32'd0);

        // Saturate at the top, then step back down.
        en = 1'b0; load = 1'b1; load_val = 4'd8;
        tick();
        check_val("ld8_b_out", b_out, 32'd8);
        load = 1'b0; en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("sat%0d_b_out", i), b_out, 32'd9);
            check_val($sformatf("sat%0d_b_wrap", i), {31'd0, b_wrap}, 32'd1);
        end
        dir = 1'b0;
        tick();
        check_val("satdn_b_out",  b_out, 32'd6);
        check_val("satdn_b_wrap", {31'd0, b_wrap}, 32'd0);

        // Load beats enable and clamps; clear beats load.
        load = 1'b1; load_val = 4'd12; en = 1'b1; dir = 1'b1;
        tick();
        check_val("clamp_a_out",  a_out, 32'd9);
        check_val("clamp_a_wrap", {31'd0, a_wrap}, 32'd0);
        check_val("clamp_b_out",  b_out, 32'd9);
        clear = 1'b1;
        tick();
        check_val("clr_a_out",  a_out, 32'd2);
        check_val("clr_a_wrap", {31'd0, a_wrap}, 32'd0);
        clear = 1'b0; load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dir = i[0];
            tick();
            check_val($sformatf("hold%0d_a_out", i), a_out, 32'd2);
            check_val($sformatf("hold%0d_a_wrap", i), {31'd0, a_wrap}, 32'd0);
        end

        // Reset mid-count overrides a pending wrap.
        en = 1'b1; dir = 1'b1;
        tick();
        check_val("mid1_a_out", a_out, 32'd5);
        tick();
        check_val("mid2_a_out", a_out, 32'd8);
        reset = 1'b1;
        tick();
        check_val("midrst_a_out",  a_out, 32'd2);
        check_val("midrst_a_wrap", {31'd0, a_wrap}, 32'd0);
        reset = 1'b0;
        tick();
        check_val("res1_a_out", a_out, 32'd5);
        tick();
        check_val("res2_a_out", a_out, 32'd8);
        tick();
        check_val("res3_a_out",  a_out, 32'd1);
        check_val("res3_a_wrap", {31'd0, a_wrap}, 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_delay_init_counter
`default_nettype wire
